// File: rtl/bch_err_scoreboard.sv
// In-order self-checking scoreboard for the BCH encode/decode chain.
// Records the expected error pattern of each encoded frame and checks the
// decoder's presence flag, error count and located-error beat stream against it.
// Optional macro BCH_SB_CAPTURE_EN adds first-failure capture outputs
// (first_fail_idx / first_fail_exp / first_fail_got).
module bch_err_scoreboard #(
  parameter int unsigned CODE_BITS = 1023,
  parameter int unsigned DATA_BITS = 1013,
  parameter int unsigned BITS      = 32,
  parameter int unsigned ERR_SZ    = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [CODE_BITS-1:0] push_err,
  input  logic                 pres_valid,
  input  logic                 pres_in,
  input  logic                 cnt_valid,
  input  logic [ERR_SZ-1:0]    cnt_in,
  input  logic                 err_first,
  input  logic                 err_valid,
  input  logic                 err_last,
  input  logic [BITS-1:0]      err_beat,
  output logic                 full,
  output logic                 wrong,
  output logic [CNT_W-1:0]     pres_mis,
  output logic [CNT_W-1:0]     cnt_mis,
  output logic [CNT_W-1:0]     err_mis,
  output logic [CNT_W-1:0]     frames_ok,
  output logic                 proto_err
`ifdef BCH_SB_CAPTURE_EN
  ,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [DATA_BITS-1:0] first_fail_exp,
  output logic [DATA_BITS-1:0] first_fail_got
`endif
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned NBEATS  = (DATA_BITS + BITS - 1) / BITS;
  localparam int unsigned KW      = $clog2(NBEATS + 1);
  localparam int unsigned SHW     = $clog2(NBEATS * BITS + 1);
  localparam int unsigned PCW     = $clog2(CODE_BITS + 1);
  localparam int unsigned CNT_MAX = (1 << ERR_SZ) - 1;

  // Saturating add of up to three events to a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Per-entry storage
  logic [DATA_BITS-1:0] mem_err [DEPTH];
  logic [ERR_SZ-1:0]    mem_cnt [DEPTH];
  logic [DEPTH-1:0]     mem_pres;
  logic [2:0]           done_q  [DEPTH];
  logic [DEPTH-1:0]     mis_q;

  logic [PW-1:0] wr_ptr, rp_pres, rp_cnt, rp_err;
  logic [PW-1:0] wr_ptr_n, rp_pres_n, rp_cnt_n, rp_err_n;

  // Location assembly state
  logic                 active, active_n;
  logic [KW-1:0]        beat_cnt, beat_cnt_n;
  logic [DATA_BITS-1:0] asm_buf, asm_buf_n;

  // Combinational decode
  logic [PCW-1:0]       pc;
  logic [ERR_SZ-1:0]    push_cnt;
  logic                 push_ok;
  logic                 pres_empty, cnt_empty, err_empty;
  logic [KW-1:0]        beat_idx;
  logic                 beat_take, in_range, err_end;
  logic [SHW-1:0]       shamt;
  logic [DATA_BITS-1:0] cur_vec;
  logic [AW-1:0]        idx   [3];
  logic [2:0]           fire, bad;
  logic [2:0]           mdone [3];
  logic [2:0]           mmis, dup, ok;
  logic [1:0]           n_ok;
  logic                 proto_set;
  logic                 full_n;

  // Popcount of the injected pattern, saturated to the count width
  always_comb begin
    pc = '0;
    for (int i = 0; i < CODE_BITS; i++) pc = pc + PCW'(push_err[i]);
    push_cnt = (32'(pc) > CNT_MAX) ? {ERR_SZ{1'b1}} : ERR_SZ'(pc);
  end

  // Check decode, beat assembly, frame resolution and next-state pointers
  always_comb begin
    push_ok    = push && !full;
    pres_empty = (rp_pres == wr_ptr);
    cnt_empty  = (rp_cnt  == wr_ptr);
    err_empty  = (rp_err  == wr_ptr);

    idx[0] = rp_pres[AW-1:0];
    idx[1] = rp_cnt[AW-1:0];
    idx[2] = rp_err[AW-1:0];

    // err_first restarts at beat 0 with an empty buffer
    beat_idx  = err_first ? '0 : beat_cnt;
    beat_take = (err_valid || err_first) && (err_first || active);
    in_range  = (beat_idx < KW'(NBEATS));
    shamt     = SHW'(beat_idx) * SHW'(BITS);
    cur_vec   = err_first ? '0 : asm_buf;
    if (beat_take && in_range) cur_vec = cur_vec | (DATA_BITS'(err_beat) << shamt);
    err_end   = beat_take && err_valid && err_last;

    fire[0] = pres_valid && !pres_empty;
    fire[1] = cnt_valid  && !cnt_empty;
    fire[2] = err_end    && !err_empty;
    bad[0]  = fire[0] && (pres_in != mem_pres[idx[0]]);
    bad[1]  = fire[1] && (cnt_in  != mem_cnt[idx[1]]);
    bad[2]  = fire[2] && (cur_vec != mem_err[idx[2]]);

    // Merge same-cycle completions that land on the same entry; count each entry once
    n_ok = '0;
    for (int j = 0; j < 3; j++) begin
      mdone[j] = done_q[idx[j]];
      mmis[j]  = mis_q[idx[j]];
      dup[j]   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (fire[k] && (idx[k] == idx[j])) begin
          mdone[j][k] = 1'b1;
          mmis[j]     = mmis[j] | bad[k];
          if (k < j) dup[j] = 1'b1;
        end
      end
      ok[j] = fire[j] && !dup[j] && (mdone[j] == 3'b111) && !mmis[j];
      n_ok  = n_ok + 2'(ok[j]);
    end

    proto_set = (push && full) || (pres_valid && pres_empty) || (cnt_valid && cnt_empty) ||
                (err_first && active) || (err_end && err_empty) ||
                (err_end && (beat_idx != KW'(NBEATS - 1)));

    wr_ptr_n  = wr_ptr  + PW'(push_ok);
    rp_pres_n = rp_pres + PW'(fire[0]);
    rp_cnt_n  = rp_cnt  + PW'(fire[1]);
    rp_err_n  = rp_err  + PW'(fire[2]);
    full_n    = ((wr_ptr_n - rp_pres_n) == PW'(DEPTH)) ||
                ((wr_ptr_n - rp_cnt_n)  == PW'(DEPTH)) ||
                ((wr_ptr_n - rp_err_n)  == PW'(DEPTH));

    active_n   = active;
    beat_cnt_n = beat_cnt;
    asm_buf_n  = asm_buf;
    if (err_end) begin
      active_n   = 1'b0;
      beat_cnt_n = '0;
      asm_buf_n  = '0;
    end else if (beat_take) begin
      active_n   = 1'b1;
      beat_cnt_n = in_range ? beat_idx + KW'(1) : beat_cnt;
      asm_buf_n  = cur_vec;
    end
  end

  // Entry payload storage, written on accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_err[wr_ptr[AW-1:0]]  <= push_err[DATA_BITS-1:0];
      mem_cnt[wr_ptr[AW-1:0]]  <= push_cnt;
      mem_pres[wr_ptr[AW-1:0]] <= |push_err;
    end
  end

  // Pointers, assembly, per-entry status, counters and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rp_pres   <= '0;
      rp_cnt    <= '0;
      rp_err    <= '0;
      active    <= 1'b0;
      beat_cnt  <= '0;
      asm_buf   <= '0;
      full      <= 1'b0;
      wrong     <= 1'b0;
      proto_err <= 1'b0;
      pres_mis  <= '0;
      cnt_mis   <= '0;
      err_mis   <= '0;
      frames_ok <= '0;
      mis_q     <= '0;
      for (int d = 0; d < DEPTH; d++) done_q[d] <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rp_pres   <= rp_pres_n;
      rp_cnt    <= rp_cnt_n;
      rp_err    <= rp_err_n;
      active    <= active_n;
      beat_cnt  <= beat_cnt_n;
      asm_buf   <= asm_buf_n;
      full      <= full_n;
      proto_err <= proto_err | proto_set;
      wrong     <= wrong | proto_set | (|bad);
      pres_mis  <= sat_add(pres_mis, 2'(bad[0]));
      cnt_mis   <= sat_add(cnt_mis,  2'(bad[1]));
      err_mis   <= sat_add(err_mis,  2'(bad[2]));
      frames_ok <= sat_add(frames_ok, n_ok);
      if (push_ok) begin
        done_q[wr_ptr[AW-1:0]] <= '0;
        mis_q[wr_ptr[AW-1:0]]  <= 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
        if (fire[j]) begin
          done_q[idx[j]] <= mdone[j];
          mis_q[idx[j]]  <= mmis[j];
        end
      end
    end
  end

`ifdef BCH_SB_CAPTURE_EN
  logic [CNT_W-1:0] mem_ord [DEPTH];
  logic [CNT_W-1:0] ord_q;
  logic             cap_done;

  // Frame ordinal stored alongside each accepted entry
  always_ff @(posedge clk) begin
    if (push_ok) mem_ord[wr_ptr[AW-1:0]] <= ord_q;
  end

  // Freeze the first location mismatch
  always_ff @(posedge clk) begin
    if (reset) begin
      ord_q          <= '0;
      cap_done       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      if (push_ok) ord_q <= sat_add(ord_q, 2'd1);
      if (bad[2] && !cap_done) begin
        cap_done       <= 1'b1;
        first_fail_idx <= mem_ord[idx[2]];
        first_fail_exp <= mem_err[idx[2]];
        first_fail_got <= cur_vec;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bch_err_scoreboard.sv
// Directed self-checking bench for bch_err_scoreboard (DEPTH=4, 4 beats of 32 bits).
module tb_bch_err_scoreboard;

  localparam int unsigned CODE_BITS = 136;
  localparam int unsigned DATA_BITS = 128;
  localparam int unsigned BITS      = 32;
  localparam int unsigned ERR_SZ    = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_W     = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 push = 1'b0;
  logic [CODE_BITS-1:0] push_err = '0;
  logic                 pres_valid = 1'b0;
  logic                 pres_in = 1'b0;
  logic                 cnt_valid = 1'b0;
  logic [ERR_SZ-1:0]    cnt_in = '0;
  logic                 err_first = 1'b0;
  logic                 err_valid = 1'b0;
  logic                 err_last = 1'b0;
  logic [BITS-1:0]      err_beat = '0;
  logic                 full, wrong, proto_err;
  logic [CNT_W-1:0]     pres_mis, cnt_mis, err_mis, frames_ok;
`ifdef BCH_SB_CAPTURE_EN
  logic [CNT_W-1:0]     first_fail_idx;
  logic [DATA_BITS-1:0] first_fail_exp, first_fail_got;
`endif

  int checks = 0;
  int failures = 0;

  bch_err_scoreboard #(
    .CODE_BITS(CODE_BITS), .DATA_BITS(DATA_BITS), .BITS(BITS),
    .ERR_SZ(ERR_SZ), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_err(push_err),
    .pres_valid(pres_valid), .pres_in(pres_in), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .err_first(err_first), .err_valid(err_valid), .err_last(err_last), .err_beat(err_beat),
    .full(full), .wrong(wrong), .pres_mis(pres_mis), .cnt_mis(cnt_mis), .err_mis(err_mis),
    .frames_ok(frames_ok), .proto_err(proto_err)
`ifdef BCH_SB_CAPTURE_EN
    , .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
    .first_fail_got(first_fail_got)
`endif
  );

  always #5 clk = ~clk;

  // One clock; outputs are read #1 after the edge, strobes then drop
  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pres_valid = 1'b0; cnt_valid = 1'b0;
    err_first = 1'b0; err_valid = 1'b0; err_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic push_frame(input logic [CODE_BITS-1:0] e);
    push = 1'b1; push_err = e; tick();
  endtask

  task automatic beat(input logic f, input logic l, input logic [BITS-1:0] d);
    err_valid = 1'b1; err_first = f; err_last = l; err_beat = d; tick();
  endtask

  task automatic send4(input logic [DATA_BITS-1:0] v);
    beat(1'b1, 1'b0, v[31:0]);
    beat(1'b0, 1'b0, v[63:32]);
    beat(1'b0, 1'b0, v[95:64]);
    beat(1'b0, 1'b1, v[127:96]);
  endtask

  task automatic pres_cnt(input logic p, input logic [ERR_SZ-1:0] c);
    pres_valid = 1'b1; pres_in = p; cnt_valid = 1'b1; cnt_in = c; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b want=0", full); end
    checks++; if (wrong !== 1'b0) begin failures++; $display("FAIL reset_wrong got=%0b want=0", wrong); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto got=%0b want=0", proto_err); end
    checks++; if ({pres_mis, cnt_mis, err_mis, frames_ok} !== 64'd0) begin failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d want=0/0/0/0", pres_mis, cnt_mis, err_mis, frames_ok); end
  endtask

  task automatic test_basic();
    do_reset();
    push_frame(136'h5);
    pres_cnt(1'b1, 4'd2);
    send4(128'h5);
    checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL basic_frames_ok got=%0d want=1", frames_ok); end
    checks++; if ({pres_mis, cnt_mis, err_mis} !== 48'd0) begin failures++;
      $display("FAIL basic_mis got=%0d/%0d/%0d want=0/0/0", pres_mis, cnt_mis, err_mis); end
    checks++; if ({wrong, proto_err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%0b%0b want=00", wrong, proto_err); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_frame('0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after4 got=%0b want=1", full); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL full_no_proto got=%0b want=0", proto_err); end
    push_frame(136'h1);
    checks++; if ({proto_err, wrong} !== 2'b11) begin failures++; $display("FAIL overflow_flags got=%0b%0b want=11", proto_err, wrong); end
    pres_valid = 1'b1; pres_in = 1'b0; tick();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after_pres got=%0b want=1", full); end
    cnt_valid = 1'b1; cnt_in = 4'd0; tick();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after_cnt got=%0b want=1", full); end
    send4('0);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_after_err got=%0b want=0", full); end
    checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL full_frames_ok got=%0d want=1", frames_ok); end
  endtask

  task automatic test_mismatch();
    logic [DATA_BITS-1:0] b40, b41;
    b40 = 128'h1 << 40;
    b41 = 128'h1 << 41;
    do_reset();
    push_frame(136'h1 << 40);
    pres_cnt(1'b1, 4'd1);
    beat(1'b1, 1'b0, b41[31:0]);
    beat(1'b0, 1'b0, b41[63:32]);
    beat(1'b0, 1'b0, b41[95:64]);
    checks++; if ({err_mis, wrong} !== {16'd0, 1'b0}) begin failures++; $display("FAIL mis_before_last got=%0d/%0b want=0/0", err_mis, wrong); end
    beat(1'b0, 1'b1, b41[127:96]);
    checks++; if (err_mis !== 16'd1) begin failures++; $display("FAIL mis_err_mis got=%0d want=1", err_mis); end
    checks++; if ({wrong, proto_err} !== 2'b10) begin failures++; $display("FAIL mis_flags got=%0b%0b want=10", wrong, proto_err); end
    checks++; if (frames_ok !== 16'd0) begin failures++; $display("FAIL mis_frames_ok got=%0d want=0", frames_ok); end
`ifdef BCH_SB_CAPTURE_EN
    checks++; if (first_fail_idx !== 16'd0) begin failures++; $display("FAIL cap_idx got=%0d want=0", first_fail_idx); end
    checks++; if (first_fail_exp !== b40) begin failures++; $display("FAIL cap_exp got=%h want=%h", first_fail_exp, b40); end
    checks++; if (first_fail_got !== b41) begin failures++; $display("FAIL cap_got got=%h want=%h", first_fail_got, b41); end
`endif
  endtask

  task automatic test_cnt_empty();
    do_reset();
    cnt_valid = 1'b1; cnt_in = 4'd3; tick();
    checks++; if ({proto_err, wrong} !== 2'b11) begin failures++; $display("FAIL cnt_empty_flags got=%0b%0b want=11", proto_err, wrong); end
    checks++; if (cnt_mis !== 16'd0) begin failures++; $display("FAIL cnt_empty_mis got=%0d want=0", cnt_mis); end
    push_frame(136'h3);
    pres_cnt(1'b1, 4'd2);
    send4(128'h3);
    checks++; if ({cnt_mis, frames_ok} !== {16'd0, 16'd1}) begin failures++;
      $display("FAIL cnt_empty_ptr got=%0d/%0d want=0/1", cnt_mis, frames_ok); end
  endtask

  task automatic test_early_last_restart();
    do_reset();
    push_frame(136'h22_00000011);
    pres_cnt(1'b1, 4'd4);
    beat(1'b1, 1'b0, 32'h11);
    beat(1'b0, 1'b0, 32'h22);
    beat(1'b0, 1'b1, 32'h0);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL early_last_proto got=%0b want=1", proto_err); end
    checks++; if ({err_mis, frames_ok} !== {16'd0, 16'd1}) begin failures++;
      $display("FAIL early_last_cmp got=%0d/%0d want=0/1", err_mis, frames_ok); end
    push_frame(136'h80);
    pres_cnt(1'b1, 4'd1);
    beat(1'b1, 1'b0, 32'hFF);
    beat(1'b0, 1'b0, 32'h1);
    send4(128'h80);
    checks++; if ({err_mis, frames_ok} !== {16'd0, 16'd2}) begin failures++;
      $display("FAIL restart_cmp got=%0d/%0d want=0/2", err_mis, frames_ok); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    push_frame(136'h1);
    push_frame(136'h1);
    beat(1'b1, 1'b0, 32'h1);
    reset = 1'b1; err_valid = 1'b1; err_beat = 32'h0; tick();
    tick();
    reset = 1'b0;
    checks++; if ({pres_mis, cnt_mis, err_mis, frames_ok} !== 64'd0) begin failures++;
      $display("FAIL rstmid_counters got=%0d/%0d/%0d/%0d want=0", pres_mis, cnt_mis, err_mis, frames_ok); end
    checks++; if ({full, wrong, proto_err} !== 3'b000) begin failures++;
      $display("FAIL rstmid_flags got=%0b%0b%0b want=000", full, wrong, proto_err); end
    push_frame(136'h9);
    pres_cnt(1'b1, 4'd2);
    send4(128'h9);
    checks++; if ({frames_ok, err_mis} !== {16'd1, 16'd0}) begin failures++;
      $display("FAIL rstmid_frame got=%0d/%0d want=1/0", frames_ok, err_mis); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_proto got=%0b want=0", proto_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_frame(136'h1);
    push_frame(136'h6);
    push = 1'b1; push_err = '0; pres_valid = 1'b1; pres_in = 1'b1; cnt_valid = 1'b1; cnt_in = 4'd1; tick();
    beat(1'b1, 1'b0, 32'h1);
    beat(1'b0, 1'b0, 32'h0);
    beat(1'b0, 1'b0, 32'h0);
    err_valid = 1'b1; err_last = 1'b1; err_beat = 32'h0;
    pres_valid = 1'b1; pres_in = 1'b1; cnt_valid = 1'b1; cnt_in = 4'd2; tick();
    checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL b2b_f0 got=%0d want=1", frames_ok); end
    send4(128'h6);
    checks++; if (frames_ok !== 16'd2) begin failures++; $display("FAIL b2b_f1 got=%0d want=2", frames_ok); end
    send4('0);
    checks++; if (frames_ok !== 16'd2) begin failures++; $display("FAIL b2b_f2_pending got=%0d want=2", frames_ok); end
    pres_cnt(1'b0, 4'd0);
    checks++; if (frames_ok !== 16'd3) begin failures++; $display("FAIL b2b_f2_resolved got=%0d want=3", frames_ok); end
    push_frame(136'h1);
    pres_cnt(1'b0, 4'd0);
    send4(128'h1);
    checks++; if ({pres_mis, cnt_mis, err_mis} !== {16'd1, 16'd1, 16'd0}) begin failures++;
      $display("FAIL b2b_f3_mis got=%0d/%0d/%0d want=1/1/0", pres_mis, cnt_mis, err_mis); end
    checks++; if ({frames_ok, wrong, proto_err} !== {16'd3, 1'b1, 1'b0}) begin failures++;
      $display("FAIL b2b_f3_final got=%0d/%0b/%0b want=3/1/0", frames_ok, wrong, proto_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_mismatch();
    test_cnt_empty();
    test_early_last_restart();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
